// File: rtl/csr_interrupt_unit_pkg.sv
// Shared types and constants for the interrupt CSR block: privilege levels, CSR ops,
// interrupt cause codes and the CSR addresses this block owns.
package csr_interrupt_unit_pkg;

   localparam int XLEN            = 32;
   localparam int ECODE_W         = 5;
   localparam int CUSTOM_IRQ_BASE = 16;

   localparam logic [11:0] CSR_SIE     = 12'h104;
   localparam logic [11:0] CSR_SIP     = 12'h144;
   localparam logic [11:0] CSR_MIDELEG = 12'h303;
   localparam logic [11:0] CSR_MIE     = 12'h304;
   localparam logic [11:0] CSR_MIP     = 12'h344;

   typedef enum logic [1:0] {
      PRIV_U = 2'b00,
      PRIV_S = 2'b01,
      PRIV_M = 2'b11
   } privilege_t;

   typedef enum logic [1:0] {
      CSR_OP_READ  = 2'b00,
      CSR_OP_WRITE = 2'b01,
      CSR_OP_SET   = 2'b10,
      CSR_OP_CLEAR = 2'b11
   } csr_op_t;

   typedef enum logic [ECODE_W-1:0] {
      IRQ_CODE_SSI = 5'd1,
      IRQ_CODE_MSI = 5'd3,
      IRQ_CODE_STI = 5'd5,
      IRQ_CODE_MTI = 5'd7,
      IRQ_CODE_SEI = 5'd9,
      IRQ_CODE_MEI = 5'd11
   } interrupt_code_t;

   typedef logic [XLEN-1:0] mideleg_t;
   typedef logic [XLEN-1:0] sie_t;
   typedef logic [XLEN-1:0] sip_t;

   localparam logic [XLEN-1:0] STD_S_IRQ_MASK = 32'h0000_0222;
   localparam logic [XLEN-1:0] STD_M_IRQ_MASK = 32'h0000_0888;

   function automatic logic [XLEN-1:0] csr_apply_op(input csr_op_t op,
                                                    input logic [XLEN-1:0] old_val,
                                                    input logic [XLEN-1:0] wdata);
      logic [XLEN-1:0] res;
      case (op)
         CSR_OP_WRITE: res = wdata;
         CSR_OP_SET:   res = old_val | wdata;
         CSR_OP_CLEAR: res = old_val & ~wdata;
         default:      res = old_val;
      endcase
      return res;
   endfunction

   function automatic logic [XLEN-1:0] custom_bits_mask(input int num_lines);
      logic [XLEN-1:0] m;
      m = '0;
      for (int i = 0; i < XLEN; i++) begin
         m[i] = (i >= CUSTOM_IRQ_BASE) && (i < CUSTOM_IRQ_BASE + num_lines);
      end
      return m;
   endfunction

endpackage

// File: rtl/csr_interrupt_unit_if.sv
// CSR access bus plus the trap-request handshake between this block and the core.
interface csr_interrupt_unit_if;
   import csr_interrupt_unit_pkg::*;

   logic                  csr_valid;
   logic [11:0]           csr_addr;
   logic [1:0]            csr_op;
   logic [XLEN-1:0]       csr_wdata;
   logic                  csr_hit;
   logic [XLEN-1:0]       csr_rdata;
   logic                  irq_pending;
   logic [ECODE_W-1:0]    irq_cause;
   logic                  irq_to_s;
   logic                  irq_ack;

   modport master (
      output csr_valid, csr_addr, csr_op, csr_wdata, irq_ack,
      input  csr_hit, csr_rdata, irq_pending, irq_cause, irq_to_s
   );

   modport slave (
      input  csr_valid, csr_addr, csr_op, csr_wdata, irq_ack,
      output csr_hit, csr_rdata, irq_pending, irq_cause, irq_to_s
   );

endinterface

// File: rtl/csr_interrupt_unit_irq_priority_encoder.sv
// Fixed-priority interrupt selector: MEI, MSI, MTI, SEI, SSI, STI, then custom
// lines from the lowest index upwards.
module irq_priority_encoder
   import csr_interrupt_unit_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic [WIDTH-1:0]   req,
   output logic               valid,
   output logic [ECODE_W-1:0] code
);

   logic unused_std_bits;
   assign unused_std_bits = ^{req[15:12], req[10], req[8], req[6], req[4], req[2], req[0]};

   always_comb begin
      valid = 1'b1;
      code  = '0;
      if      (req[11]) code = IRQ_CODE_MEI;
      else if (req[3])  code = IRQ_CODE_MSI;
      else if (req[7])  code = IRQ_CODE_MTI;
      else if (req[9])  code = IRQ_CODE_SEI;
      else if (req[1])  code = IRQ_CODE_SSI;
      else if (req[5])  code = IRQ_CODE_STI;
      else begin
         valid = 1'b0;
         // Scan downwards so the lowest-numbered active custom line wins.
         for (int i = WIDTH - 1; i >= CUSTOM_IRQ_BASE; i--) begin
            if (req[i]) begin
               valid = 1'b1;
               code  = ECODE_W'(i);
            end
         end
      end
   end

endmodule

// File: rtl/csr_interrupt_unit.sv
// Interrupt CSR block: owns mie/mip/mideleg (and sie/sip views), synchronises raw
// interrupt lines, and produces one registered prioritised trap request.
module csr_interrupt_unit
   import csr_interrupt_unit_pkg::*;
#(
   parameter int          NUM_CUSTOM_IRQ   = 16,
   parameter logic [15:0] CUSTOM_EDGE_MASK = 16'h0,
   parameter int          SYNC_STAGES      = 2,
   parameter bit          S_MODE           = 1'b1
) (
   input  logic                      clk,
   input  logic                      rst,
   csr_interrupt_unit_if.slave       bus,
   input  logic                      m_ext_irq,
   input  logic                      s_ext_irq,
   input  logic                      m_timer_irq,
   input  logic                      m_soft_irq,
   input  logic [NUM_CUSTOM_IRQ-1:0] custom_irq,
   input  privilege_t                current_privilege,
   input  logic                      mstatus_mie,
   input  logic                      mstatus_sie
);

   localparam int IRQ_W = CUSTOM_IRQ_BASE + NUM_CUSTOM_IRQ;
   localparam int RAW_W = 4 + NUM_CUSTOM_IRQ;

   localparam logic [XLEN-1:0] CUSTOM_BITS   = custom_bits_mask(NUM_CUSTOM_IRQ);
   localparam logic [XLEN-1:0] S_BITS        = S_MODE ? STD_S_IRQ_MASK : '0;
   localparam logic [XLEN-1:0] MIE_WMASK     = STD_M_IRQ_MASK | S_BITS | CUSTOM_BITS;
   localparam logic [XLEN-1:0] MIDELEG_WMASK = S_MODE ? (S_BITS | CUSTOM_BITS) : '0;
   localparam logic [NUM_CUSTOM_IRQ-1:0] EDGE_N = CUSTOM_EDGE_MASK[NUM_CUSTOM_IRQ-1:0];

   logic [SYNC_STAGES-1:0][RAW_W-1:0] sync_q, sync_d;
   logic [NUM_CUSTOM_IRQ-1:0]         custom_prev_q, custom_prev_d;
   logic [NUM_CUSTOM_IRQ-1:0]         edge_q, edge_d;
   logic [XLEN-1:0]                   mie_q, mie_d;
   mideleg_t                          mideleg_q, mideleg_d;
   logic                              ssip_q, ssip_d;
   logic                              stip_q, stip_d;
   logic                              seip_sw_q, seip_sw_d;
   logic                              csr_hit_q, csr_hit_d;
   logic [XLEN-1:0]                   csr_rdata_q, csr_rdata_d;
   logic                              irq_pending_q, irq_pending_d;
   logic [ECODE_W-1:0]                irq_cause_q, irq_cause_d;
   logic                              irq_to_s_q, irq_to_s_d;

   logic [RAW_W-1:0]          raw_irq, synced;
   logic [NUM_CUSTOM_IRQ-1:0] custom_sync, rise, edge_clr, ack_clr;
   logic [XLEN-1:0]           mip_val, mip_rmw, new_val, rd_val;
   sie_t                      sie_val;
   sip_t                      sip_val;
   logic                      is_write;
   csr_op_t                   op;

   logic [IRQ_W-1:0]   taken, m_req, s_req;
   logic               m_en, s_en, m_valid, s_valid;
   logic [ECODE_W-1:0] m_code, s_code;

   assign raw_irq     = {custom_irq, m_soft_irq, m_timer_irq, s_ext_irq, m_ext_irq};
   assign synced      = sync_q[SYNC_STAGES-1];
   assign custom_sync = synced[4 +: NUM_CUSTOM_IRQ];
   assign op          = csr_op_t'(bus.csr_op);
   assign is_write    = bus.csr_valid && (op != CSR_OP_READ);

   always_comb begin
      sync_d[0] = raw_irq;
      for (int s = 1; s < SYNC_STAGES; s++) begin
         sync_d[s] = sync_q[s-1];
      end
   end

   // Architectural mip view: hardware lines, software S bits, and per-line edge/level custom bits.
   always_comb begin
      mip_val     = '0;
      mip_val[1]  = ssip_q;
      mip_val[3]  = synced[3];
      mip_val[5]  = stip_q;
      mip_val[7]  = synced[2];
      mip_val[9]  = seip_sw_q | (synced[1] & S_MODE);
      mip_val[11] = synced[0];
      mip_val[CUSTOM_IRQ_BASE +: NUM_CUSTOM_IRQ] = (edge_q & EDGE_N) | (custom_sync & ~EDGE_N);
      mip_rmw     = mip_val;
      mip_rmw[9]  = seip_sw_q;
      sie_val     = mie_q & mideleg_q;
      sip_val     = mip_val & mideleg_q;
   end

   // CSR decode: registered read of the old value, write effect on the same edge.
   always_comb begin
      mie_d     = mie_q;
      mideleg_d = mideleg_q;
      ssip_d    = ssip_q;
      stip_d    = stip_q;
      seip_sw_d = seip_sw_q;
      edge_clr  = '0;
      new_val   = '0;
      rd_val    = '0;
      csr_hit_d = 1'b0;
      if (bus.csr_valid) begin
         case (bus.csr_addr)
            CSR_MIE: begin
               csr_hit_d = 1'b1;
               rd_val    = mie_q;
               new_val   = csr_apply_op(op, mie_q, bus.csr_wdata);
               if (is_write) mie_d = new_val & MIE_WMASK;
            end
            CSR_SIE: begin
               csr_hit_d = 1'b1;
               rd_val    = sie_val;
               new_val   = csr_apply_op(op, sie_val, bus.csr_wdata);
               if (is_write) mie_d = (mie_q & ~mideleg_q) | (new_val & mideleg_q & MIE_WMASK);
            end
            CSR_MIDELEG: begin
               csr_hit_d = 1'b1;
               rd_val    = mideleg_q;
               new_val   = csr_apply_op(op, mideleg_q, bus.csr_wdata);
               if (is_write) mideleg_d = new_val & MIDELEG_WMASK;
            end
            CSR_MIP: begin
               csr_hit_d = 1'b1;
               rd_val    = mip_val;
               new_val   = csr_apply_op(op, mip_rmw, bus.csr_wdata);
               if (is_write) begin
                  ssip_d    = new_val[1] & S_BITS[1];
                  stip_d    = new_val[5] & S_BITS[5];
                  seip_sw_d = new_val[9] & S_BITS[9];
                  edge_clr  = ~new_val[CUSTOM_IRQ_BASE +: NUM_CUSTOM_IRQ] & EDGE_N;
               end
            end
            CSR_SIP: begin
               csr_hit_d = 1'b1;
               rd_val    = sip_val;
               new_val   = csr_apply_op(op, mip_rmw & mideleg_q, bus.csr_wdata);
               if (is_write) begin
                  if (mideleg_q[1]) ssip_d = new_val[1];
                  edge_clr = ~new_val[CUSTOM_IRQ_BASE +: NUM_CUSTOM_IRQ] & EDGE_N
                             & mideleg_q[CUSTOM_IRQ_BASE +: NUM_CUSTOM_IRQ];
               end
            end
            default: ;
         endcase
      end
      csr_rdata_d = rd_val;
   end

   // A fresh rising edge always wins over a same-cycle clear from ack or CSR.
   always_comb begin
      ack_clr = '0;
      if (bus.irq_ack && irq_pending_q) begin
         for (int i = 0; i < NUM_CUSTOM_IRQ; i++) begin
            if (irq_cause_q == ECODE_W'(CUSTOM_IRQ_BASE + i)) ack_clr[i] = EDGE_N[i];
         end
      end
      rise          = custom_sync & ~custom_prev_q & EDGE_N;
      custom_prev_d = custom_sync;
      edge_d        = (edge_q & ~(edge_clr | ack_clr)) | rise;
   end

   always_comb begin
      m_en  = (current_privilege != PRIV_M) || mstatus_mie;
      s_en  = (current_privilege == PRIV_U) || ((current_privilege == PRIV_S) && mstatus_sie);
      taken = mip_val[IRQ_W-1:0] & mie_q[IRQ_W-1:0];
      m_req = taken & ~mideleg_q[IRQ_W-1:0] & {IRQ_W{m_en}};
      s_req = taken & mideleg_q[IRQ_W-1:0] & {IRQ_W{s_en}};
   end

   irq_priority_encoder #(.WIDTH(IRQ_W)) u_m_prio (
      .req   (m_req),
      .valid (m_valid),
      .code  (m_code)
   );

   irq_priority_encoder #(.WIDTH(IRQ_W)) u_s_prio (
      .req   (s_req),
      .valid (s_valid),
      .code  (s_code)
   );

   always_comb begin
      irq_pending_d = m_valid | s_valid;
      irq_to_s_d    = !m_valid && s_valid;
      irq_cause_d   = '0;
      if (m_valid)      irq_cause_d = m_code;
      else if (s_valid) irq_cause_d = s_code;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync_q        <= '0;
         custom_prev_q <= '0;
         edge_q        <= '0;
         mie_q         <= '0;
         mideleg_q     <= '0;
         ssip_q        <= 1'b0;
         stip_q        <= 1'b0;
         seip_sw_q     <= 1'b0;
         csr_hit_q     <= 1'b0;
         csr_rdata_q   <= '0;
         irq_pending_q <= 1'b0;
         irq_cause_q   <= '0;
         irq_to_s_q    <= 1'b0;
      end else begin
         sync_q        <= sync_d;
         custom_prev_q <= custom_prev_d;
         edge_q        <= edge_d;
         mie_q         <= mie_d;
         mideleg_q     <= mideleg_d;
         ssip_q        <= ssip_d;
         stip_q        <= stip_d;
         seip_sw_q     <= seip_sw_d;
         csr_hit_q     <= csr_hit_d;
         csr_rdata_q   <= csr_rdata_d;
         irq_pending_q <= irq_pending_d;
         irq_cause_q   <= irq_cause_d;
         irq_to_s_q    <= irq_to_s_d;
      end
   end

   assign bus.csr_hit     = csr_hit_q;
   assign bus.csr_rdata   = csr_rdata_q;
   assign bus.irq_pending = irq_pending_q;
   assign bus.irq_cause   = irq_cause_q;
   assign bus.irq_to_s    = irq_to_s_q;

endmodule

// File: tb/tb_csr_interrupt_unit.sv
// Directed bench for csr_interrupt_unit; expected responses are queued by the driver
// and compared by independent monitors for CSR reads and trap-request outputs.
module tb_csr_interrupt_unit;
   import csr_interrupt_unit_pkg::*;

   typedef struct packed {
      logic        hit;
      logic [31:0] rdata;
   } csr_rsp_t;

   typedef struct packed {
      logic       pending;
      logic [4:0] cause;
      logic       to_s;
   } irq_exp_t;

   logic        clk;
   logic        rst;
   logic        m_ext_irq, s_ext_irq, m_timer_irq, m_soft_irq;
   logic [15:0] custom_irq;
   privilege_t  priv;
   logic        mstatus_mie, mstatus_sie;

   csr_rsp_t csr_q[$];
   string    csr_name_q[$];
   irq_exp_t irq_q[$];
   string    irq_name_q[$];
   int       n_checks = 0;
   int       n_fail   = 0;
   logic     acc_seen;
   event     irq_chk_ev;
   csr_rsp_t csr_exp;
   string    csr_nm;
   irq_exp_t irq_exp;
   string    irq_nm;

   csr_interrupt_unit_if bus_if ();

   csr_interrupt_unit #(
      .NUM_CUSTOM_IRQ   (16),
      .CUSTOM_EDGE_MASK (16'h0001),
      .SYNC_STAGES      (2),
      .S_MODE           (1'b1)
   ) dut (
      .clk               (clk),
      .rst               (rst),
      .bus               (bus_if.slave),
      .m_ext_irq         (m_ext_irq),
      .s_ext_irq         (s_ext_irq),
      .m_timer_irq       (m_timer_irq),
      .m_soft_irq        (m_soft_irq),
      .custom_irq        (custom_irq),
      .current_privilege (priv),
      .mstatus_mie       (mstatus_mie),
      .mstatus_sie       (mstatus_sie)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Response monitor: a CSR access seen at a rising edge produces a response to check.
   always @(posedge clk or posedge rst) begin
      if (rst) acc_seen <= 1'b0;
      else     acc_seen <= bus_if.csr_valid;
   end

   always @(negedge clk) begin
      if (acc_seen) begin
         n_checks++;
         if (csr_q.size() == 0) begin
            n_fail++;
            $display("[TB] FAIL csr_unexpected_response: hit=%0b rdata=%h, required no response",
                     bus_if.csr_hit, bus_if.csr_rdata);
         end else begin
            csr_exp = csr_q.pop_front();
            csr_nm  = csr_name_q.pop_front();
            if (bus_if.csr_hit !== csr_exp.hit || bus_if.csr_rdata !== csr_exp.rdata) begin
               n_fail++;
               $display("[TB] FAIL %s: hit=%0b rdata=%h, required hit=%0b rdata=%h",
                        csr_nm, bus_if.csr_hit, bus_if.csr_rdata, csr_exp.hit, csr_exp.rdata);
            end
         end
      end
   end

   initial begin
      forever begin
         @(irq_chk_ev);
         while (irq_q.size() > 0) begin
            irq_exp = irq_q.pop_front();
            irq_nm  = irq_name_q.pop_front();
            n_checks++;
            if (bus_if.irq_pending !== irq_exp.pending || bus_if.irq_cause !== irq_exp.cause ||
                bus_if.irq_to_s !== irq_exp.to_s) begin
               n_fail++;
               $display("[TB] FAIL %s: pending=%0b cause=%0d to_s=%0b, required pending=%0b cause=%0d to_s=%0b",
                        irq_nm, bus_if.irq_pending, bus_if.irq_cause, bus_if.irq_to_s,
                        irq_exp.pending, irq_exp.cause, irq_exp.to_s);
            end
         end
      end
   end

   task automatic cycles(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic applyStimulus(input csr_op_t op, input logic [11:0] addr, input logic [31:0] wdata,
                                input logic exp_hit, input logic [31:0] exp_rdata, input string name);
      bus_if.csr_valid = 1'b1;
      bus_if.csr_op    = op;
      bus_if.csr_addr  = addr;
      bus_if.csr_wdata = wdata;
      csr_q.push_back(csr_rsp_t'{exp_hit, exp_rdata});
      csr_name_q.push_back(name);
      @(negedge clk);
      bus_if.csr_valid = 1'b0;
      bus_if.csr_op    = CSR_OP_READ;
      bus_if.csr_addr  = 12'h000;
      bus_if.csr_wdata = 32'h0;
   endtask

   task automatic checkOutput(input logic pending, input logic [4:0] cause, input logic to_s,
                              input string name);
      irq_q.push_back(irq_exp_t'{pending, cause, to_s});
      irq_name_q.push_back(name);
      -> irq_chk_ev;
   endtask

   task automatic pulse_line0();
      custom_irq[0] = 1'b1;
      cycles(1);
      custom_irq[0] = 1'b0;
   endtask

   task automatic ack_pulse();
      bus_if.irq_ack = 1'b1;
      cycles(1);
      bus_if.irq_ack = 1'b0;
   endtask

   initial begin
      #100000;
      $display("[TB] FAIL watchdog: simulation still running, required completion");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      rst = 1'b1;
      m_ext_irq = 1'b0; s_ext_irq = 1'b0; m_timer_irq = 1'b0; m_soft_irq = 1'b0;
      custom_irq = 16'h0;
      priv = PRIV_M;
      mstatus_mie = 1'b0; mstatus_sie = 1'b0;
      bus_if.csr_valid = 1'b0; bus_if.csr_op = CSR_OP_READ;
      bus_if.csr_addr = 12'h000; bus_if.csr_wdata = 32'h0; bus_if.irq_ack = 1'b0;
      cycles(3);
      rst = 1'b0;
      $display("[TB] reset released");

      checkOutput(1'b0, 5'd0, 1'b0, "reset_irq_outputs");
      applyStimulus(CSR_OP_READ, CSR_MIE, 32'h0, 1'b1, 32'h0, "reset_mie");
      applyStimulus(CSR_OP_READ, CSR_MIP, 32'h0, 1'b1, 32'h0, "reset_mip");
      applyStimulus(CSR_OP_WRITE, 12'h300, 32'hFFFF_FFFF, 1'b0, 32'h0, "unknown_addr");

      // Machine timer with exact synchroniser + output register latency
      applyStimulus(CSR_OP_WRITE, CSR_MIE, 32'h0000_0880, 1'b1, 32'h0, "mie_write_880");
      mstatus_mie = 1'b1;
      m_timer_irq = 1'b1;
      cycles(2);
      checkOutput(1'b0, 5'd0, 1'b0, "mtimer_not_yet");
      cycles(1);
      checkOutput(1'b1, 5'd7, 1'b0, "mtimer_taken");
      m_ext_irq = 1'b1;
      cycles(3);
      checkOutput(1'b1, 5'd11, 1'b0, "mext_over_mtimer");
      applyStimulus(CSR_OP_READ, CSR_MIP, 32'h0, 1'b1, 32'h0000_0880, "mip_meip_mtip");
      m_ext_irq = 1'b0;
      cycles(3);
      checkOutput(1'b1, 5'd7, 1'b0, "mtimer_after_mext_drop");
      m_timer_irq = 1'b0;
      applyStimulus(CSR_OP_WRITE, CSR_MIE, 32'h0, 1'b1, 32'h0000_0880, "mie_clear_old");
      cycles(3);
      checkOutput(1'b0, 5'd0, 1'b0, "idle_after_timer");

      // Delegation of supervisor timer
      applyStimulus(CSR_OP_WRITE, CSR_MIDELEG, 32'hFFFF_FFFF, 1'b1, 32'h0, "mideleg_first_write");
      applyStimulus(CSR_OP_WRITE, CSR_MIDELEG, 32'h0000_0020, 1'b1, 32'hFFFF_0222, "mideleg_writable_mask");
      applyStimulus(CSR_OP_WRITE, CSR_MIP, 32'h0000_0020, 1'b1, 32'h0, "mip_set_stip");
      applyStimulus(CSR_OP_WRITE, CSR_MIE, 32'h0000_0020, 1'b1, 32'h0, "mie_write_stie");
      priv = PRIV_S;
      mstatus_sie = 1'b1;
      cycles(2);
      checkOutput(1'b1, 5'd5, 1'b1, "deleg_sti_in_s");
      applyStimulus(CSR_OP_READ, CSR_SIP, 32'h0, 1'b1, 32'h0000_0020, "sip_view");
      applyStimulus(CSR_OP_READ, CSR_SIE, 32'h0, 1'b1, 32'h0000_0020, "sie_view");
      priv = PRIV_M;
      cycles(2);
      checkOutput(1'b0, 5'd0, 1'b0, "deleg_blocked_in_m");
      priv = PRIV_U;
      mstatus_sie = 1'b0;
      cycles(2);
      checkOutput(1'b1, 5'd5, 1'b1, "deleg_taken_in_u");
      priv = PRIV_S;
      cycles(2);
      checkOutput(1'b0, 5'd0, 1'b0, "deleg_s_sie_off");
      priv = PRIV_M;
      applyStimulus(CSR_OP_CLEAR, CSR_MIP, 32'h0000_0020, 1'b1, 32'h0000_0020, "mip_clear_stip");
      applyStimulus(CSR_OP_WRITE, CSR_MIE, 32'h0, 1'b1, 32'h0000_0020, "mie_clear_stie");
      applyStimulus(CSR_OP_WRITE, CSR_MIDELEG, 32'h0, 1'b1, 32'h0000_0020, "mideleg_clear");

      // Edge-latched custom line 0
      applyStimulus(CSR_OP_WRITE, CSR_MIE, 32'h0001_0000, 1'b1, 32'h0, "mie_custom0");
      pulse_line0();
      cycles(4);
      checkOutput(1'b1, 5'd16, 1'b0, "edge_pending");
      applyStimulus(CSR_OP_READ, CSR_MIP, 32'h0, 1'b1, 32'h0001_0000, "edge_latched_mip");
      ack_pulse();
      applyStimulus(CSR_OP_READ, CSR_MIP, 32'h0, 1'b1, 32'h0, "edge_cleared_by_ack");
      checkOutput(1'b0, 5'd0, 1'b0, "pending_drop_after_ack");

      // Ack in the same cycle as a fresh rising edge keeps the latch set
      pulse_line0();
      cycles(4);
      checkOutput(1'b1, 5'd16, 1'b0, "edge2_pending");
      custom_irq[0] = 1'b1;
      cycles(1);
      custom_irq[0] = 1'b0;
      cycles(1);
      ack_pulse();
      applyStimulus(CSR_OP_READ, CSR_MIP, 32'h0, 1'b1, 32'h0001_0000, "ack_edge_race_kept");
      applyStimulus(CSR_OP_CLEAR, CSR_MIP, 32'h0001_0000, 1'b1, 32'h0001_0000, "csr_clear_edge_old");
      applyStimulus(CSR_OP_READ, CSR_MIP, 32'h0, 1'b1, 32'h0, "csr_clear_edge_done");
      checkOutput(1'b0, 5'd0, 1'b0, "pending_drop_after_clear");

      // Ack without a pending request must not clear the latch
      applyStimulus(CSR_OP_WRITE, CSR_MIE, 32'h0, 1'b1, 32'h0001_0000, "mie_mask_custom0");
      pulse_line0();
      cycles(4);
      checkOutput(1'b0, 5'd0, 1'b0, "masked_edge_no_pending");
      ack_pulse();
      applyStimulus(CSR_OP_READ, CSR_MIP, 32'h0, 1'b1, 32'h0001_0000, "ack_ignored_when_idle");
      applyStimulus(CSR_OP_CLEAR, CSR_MIP, 32'h0001_0000, 1'b1, 32'h0001_0000, "clear_masked_edge");

      // mip writable bits and SEIP composition
      applyStimulus(CSR_OP_WRITE, CSR_MIP, 32'hFFFF_FFFF, 1'b1, 32'h0, "mip_write_all");
      applyStimulus(CSR_OP_CLEAR, CSR_MIP, 32'hFFFF_FFFF, 1'b1, 32'h0000_0222, "mip_writable_mask");
      s_ext_irq = 1'b1;
      cycles(3);
      applyStimulus(CSR_OP_SET, CSR_MIP, 32'h0000_0200, 1'b1, 32'h0000_0200, "seip_from_input");
      s_ext_irq = 1'b0;
      cycles(3);
      applyStimulus(CSR_OP_CLEAR, CSR_MIP, 32'h0000_0200, 1'b1, 32'h0000_0200, "seip_sw_bit_held");
      applyStimulus(CSR_OP_READ, CSR_MIP, 32'h0, 1'b1, 32'h0, "seip_cleared");

      // Level custom lines and standard-over-custom priority
      applyStimulus(CSR_OP_WRITE, CSR_MIE, 32'h0028_0008, 1'b1, 32'h0, "mie_custom_msi");
      custom_irq = 16'h0028;
      cycles(4);
      checkOutput(1'b1, 5'd19, 1'b0, "custom_lowest_index");
      applyStimulus(CSR_OP_READ, CSR_MIP, 32'h0, 1'b1, 32'h0028_0000, "mip_level_custom");
      m_soft_irq = 1'b1;
      cycles(4);
      checkOutput(1'b1, 5'd3, 1'b0, "msi_over_custom");
      mstatus_mie = 1'b0;
      cycles(2);
      checkOutput(1'b0, 5'd0, 1'b0, "m_blocked_mie_off");
      priv = PRIV_S;
      cycles(2);
      checkOutput(1'b1, 5'd3, 1'b0, "m_target_from_s");

      // Asynchronous reset while an edge is latched
      priv = PRIV_M;
      mstatus_mie = 1'b1;
      custom_irq = 16'h0;
      m_soft_irq = 1'b0;
      applyStimulus(CSR_OP_WRITE, CSR_MIE, 32'h0001_0000, 1'b1, 32'h0028_0008, "mie_before_reset");
      pulse_line0();
      cycles(4);
      checkOutput(1'b1, 5'd16, 1'b0, "pre_reset_pending");
      rst = 1'b1;
      #1;
      checkOutput(1'b0, 5'd0, 1'b0, "reset_async_clear");
      cycles(2);
      rst = 1'b0;
      checkOutput(1'b0, 5'd0, 1'b0, "reset_release_irq");
      applyStimulus(CSR_OP_READ, CSR_MIP, 32'h0, 1'b1, 32'h0, "reset_release_mip");
      applyStimulus(CSR_OP_READ, CSR_MIE, 32'h0, 1'b1, 32'h0, "reset_release_mie");

      cycles(3);
      n_checks++;
      if (csr_q.size() != 0 || irq_q.size() != 0) begin
         n_fail++;
         $display("[TB] FAIL scoreboard_drain: csr_left=%0d irq_left=%0d, required 0 and 0",
                  csr_q.size(), irq_q.size());
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
